sbqm_person_counter: RTL and testbench

//  Upstream stage of the SBqM queue-status logic. Turns the entry-door and

---
 rtl/sbqm_person_counter.sv | 96 +++++++++
 tb/tb_sbqm_person_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbqm_person_counter.sv
// Occupancy counter for the SBqM queue-status chain.
// The front and back photocells are synchronised and debounced. A person is
// counted when their beam is restored (debounced level falls 1->0). Pcount
// saturates at 0 and 2^N-1, and a flag reports any attempt to go past either end.
module sbqm_person_counter #(
   parameter int N   = 3,
   parameter int DEB = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         front_sensor,
   input  logic         back_sensor,
   output logic [N-1:0] Pcount,
   output logic         enter_pulse,
   output logic         exit_pulse,
   output logic         overflow_err,
   output logic         underflow_err
);

   // Terminal count for the debounce timer. DEB=1 accepts a change on the
   // first cycle it is seen at s2.
   localparam logic [7:0]   DEB_TC = 8'(DEB - 1);
   localparam logic [N-1:0] P_MAX  = '1;

   // Bit 0 is the front (entry) sensor and bit 1 is the back (exit) sensor.
   logic [1:0] s1;
   logic [1:0] s2;
   logic [1:0] stable;
   logic [1:0] stable_d;
   logic [7:0] cnt [2];
   logic       entry;
   logic       leave;

   // Two-flop synchroniser with no logic between the stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {back_sensor, front_sensor};
         s2 <= s1;
      end
   end

   // Debounce: a new level is accepted after DEB consecutive cycles.
   // Any return to the stable level restarts the timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable   <= '0;
         stable_d <= '0;
         cnt[0]   <= '0;
         cnt[1]   <= '0;
      end else begin
         stable_d <= stable;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_TC) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   // A restored beam (debounced fall) marks a completed passage.
   assign entry = stable_d[0] & ~stable[0];
   assign leave = stable_d[1] & ~stable[1];

   // Saturating occupancy update. The strobes are registered on the same edge.
   // If both doors fire together, the count is unchanged and no error is raised.
   always_ff @(posedge clk) begin
      if (reset) begin
         Pcount        <= '0;
         enter_pulse   <= 1'b0;
         exit_pulse    <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         enter_pulse   <= entry;
         exit_pulse    <= leave;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
         if (entry && !leave) begin
            if (Pcount == P_MAX) overflow_err <= 1'b1;
            else                 Pcount       <= Pcount + 1'b1;
         end else if (leave && !entry) begin
            if (Pcount == '0) underflow_err <= 1'b1;
            else              Pcount        <= Pcount - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sbqm_person_counter.sv
// Bench for sbqm_person_counter. A window-based reference model predicts the
// strobes and pushes them into a scoreboard, and a monitor pops and compares
// those entries whenever the DUT raises any strobe.
module tb_sbqm_person_counter;
   localparam int N    = 3;
   localparam int DEB  = 4;
   localparam int PMAX = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         front_sensor = 1'b0;
   logic         back_sensor = 1'b0;
   logic [N-1:0] Pcount;
   logic         enter_pulse, exit_pulse, overflow_err, underflow_err;

   sbqm_person_counter #(.N(N), .DEB(DEB)) dut (
      .clk(clk), .reset(reset),
      .front_sensor(front_sensor), .back_sensor(back_sensor),
      .Pcount(Pcount), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         en;
      logic         ex;
      logic         ov;
      logic         un;
      logic [N-1:0] pc;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e, mon_e, act_e;
   int   n_vec = 0, n_err = 0;
   int   ovf_seen = 0, unf_seen = 0, both_seen = 0;

   // Reference model. Each sensor's accepted level flips once the last DEB
   // samples seen after the two-stage delay all disagree with it. People are
   // counted on the cycle after a 1->0 flip.
   int             m_pc = 0;
   bit             m_s1 [2];
   bit             m_s2 [2];
   bit             m_lvl [2];
   bit             m_fell [2];
   logic [DEB-1:0] m_win [2];
   logic [DEB-1:0] all_ones = '1;
   bit             m_en, m_ex;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_fell[i] = 0; m_win[i] = '0;
         end
         m_pc = 0;
      end else begin
         m_en = m_fell[0];
         m_ex = m_fell[1];
         if (m_en || m_ex) begin
            m_e = '0;
            m_e.en = m_en;
            m_e.ex = m_ex;
            if (m_en && !m_ex) begin
               if (m_pc == PMAX) m_e.ov = 1'b1; else m_pc = m_pc + 1;
            end else if (m_ex && !m_en) begin
               if (m_pc == 0) m_e.un = 1'b1; else m_pc = m_pc - 1;
            end
            m_e.pc = m_pc[N-1:0];
            sb_q.push_back(m_e);
         end
         for (int i = 0; i < 2; i++) begin
            m_win[i]  = {m_win[i][DEB-2:0], m_s2[i]};
            m_fell[i] = 0;
            if (m_win[i] == (m_lvl[i] ? '0 : all_ones)) begin
               m_fell[i] = m_lvl[i];
               m_lvl[i]  = ~m_lvl[i];
            end
         end
         m_s2[0] = m_s1[0];
         m_s2[1] = m_s1[1];
         m_s1[0] = front_sensor;
         m_s1[1] = back_sensor;
      end
   end

   // Monitor: pops one scoreboard entry per strobe cycle and tracks Pcount every cycle.
   always @(negedge clk) begin
      if (enter_pulse | exit_pulse | overflow_err | underflow_err) begin
         if (overflow_err) ovf_seen++;
         if (underflow_err) unf_seen++;
         if (enter_pulse && exit_pulse) both_seen++;
         act_e = {enter_pulse, exit_pulse, overflow_err, underflow_err, Pcount};
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe t=%0t got en/ex/ov/un/pc=%b", $time, act_e);
         end else begin
            mon_e = sb_q.pop_front();
            if (act_e != mon_e) begin
               n_err++;
               $display("FAIL strobe_cmp t=%0t got en/ex/ov/un/pc=%b expected %b",
                        $time, act_e, mon_e);
            end
         end
      end
      n_vec++;
      if (Pcount != m_pc[N-1:0]) begin
         n_err++;
         $display("FAIL pcount_track t=%0t got %0d expected %0d", $time, Pcount, m_pc);
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Called at a falling edge: hold the levels for n cycles.
   task automatic drive(input bit f, input bit b, input int n);
      front_sensor = f;
      back_sensor  = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 2);
      reset = 1'b0;
      drive(0, 0, 2);
   endtask

   task automatic person_in();
      drive(1, 0, 6);
      drive(0, 0, 9);
   endtask

   task automatic person_out();
      drive(0, 1, 6);
      drive(0, 0, 9);
   endtask

   int lat, base, rem_f, rem_b;
   bit lf, lb;

   initial begin
      @(negedge clk);
      reset = 1'b1;
      drive(0, 0, 3);
      check("reset_pcount", Pcount, 0);
      check("reset_strobes", {enter_pulse, exit_pulse, overflow_err, underflow_err}, 0);
      reset = 1'b0;
      drive(0, 0, 4);

      // A 10-cycle front pulse is counted on the 7th edge after the fall.
      drive(1, 0, 10);
      front_sensor = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (enter_pulse) begin lat = k; break; end
      end
      check("enter_latency", lat, 7);
      check("first_entry", Pcount, 1);
      @(negedge clk);
      drive(0, 0, 10);

      // A 3-cycle glitch must not be counted.
      drive(1, 0, 3);
      drive(0, 0, 12);
      check("glitch_hold", Pcount, 1);

      // Eight entries from empty: saturate at 7 with one overflow.
      do_reset();
      base = ovf_seen;
      repeat (8) person_in();
      check("saturate_max", Pcount, PMAX);
      check("overflow_once", ovf_seen - base, 1);

      // An exit while empty raises underflow and holds at 0.
      do_reset();
      base = unf_seen;
      person_out();
      check("underflow_hold", Pcount, 0);
      check("underflow_once", unf_seen - base, 1);

      // Simultaneous release at Pcount=3 leaves the count unchanged.
      do_reset();
      repeat (3) person_in();
      base = both_seen;
      drive(1, 1, 6);
      drive(0, 0, 10);
      check("both_hold", Pcount, 3);
      check("both_pulses", both_seen - base, 1);

      // Reset while front is held; the later fall counts from zero.
      do_reset();
      repeat (5) person_in();
      drive(1, 0, 8);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midreset_clear", Pcount, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(1, 0, 10);
      drive(0, 0, 10);
      check("after_reset_fall", Pcount, 1);

      // Random segment lengths mix glitches with real passages, plus rare resets.
      rem_f = 1; rem_b = 1; lf = 0; lb = 0;
      for (int c = 0; c < 4000; c++) begin
         rem_f--;
         if (rem_f == 0) begin lf = ~lf; rem_f = $urandom_range(1, 12); end
         rem_b--;
         if (rem_b == 0) begin lb = ~lb; rem_b = $urandom_range(1, 12); end
         reset = ($urandom_range(0, 399) == 0);
         drive(lf, lb, 1);
      end
      reset = 1'b0;
      drive(0, 0, 20);
      check("sb_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
